// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall merge, exception flush sequencing and stall watchdog.
// Optional perf counters under `PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_LIMIT  = 1024,
  parameter int STALL_CNT_W  = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_n;
  logic [3:0] fcnt, fcnt_n;
  logic [31:0] pc_q;
  logic [STALL_CNT_W-1:0] scnt, scnt_n;
  logic to_q, acc;
  logic [5:0] req;
  always_comb begin
    req = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
          stallreq_id ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
    acc = !rst && state == IDLE && excp_valid;
    flush = !rst && (state == FLUSH || acc);
    new_pc = !flush ? 32'h0 : state == FLUSH ? pc_q : excp_pc;
    stall = (rst || flush) ? 6'b0 : req;
    stall_timeout = !rst && to_q;
    state_n = state;
    fcnt_n = fcnt;
    if (acc && FLUSH_CYCLES > 1) begin
      state_n = FLUSH;
      fcnt_n = 4'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      state_n = fcnt == 4'd1 ? IDLE : FLUSH;
      fcnt_n = fcnt - 4'd1;
    end
    scnt_n = stall == 6'b0 ? '0 :
             scnt == STALL_CNT_W'(STALL_LIMIT) ? scnt : scnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fcnt <= 4'd0;
      pc_q <= 32'h0;
      scnt <= '0;
      to_q <= 1'b0;
    end else begin
      state <= state_n;
      fcnt <= fcnt_n;
      pc_q <= acc ? excp_pc : pc_q;
      scnt <= scnt_n;
      to_q <= to_q | (scnt_n == STALL_CNT_W'(STALL_LIMIT));
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      perf_stall_cyc <= perf_stall_cyc + {31'h0, stall != 6'b0};
      perf_flush_cnt <= perf_flush_cnt + {31'h0, acc};
    end
  end
`else
  assign perf_stall_cyc = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus against a cycle-level reference model.
module tb_pipe_ctrl;
  localparam int FC = 3;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic rst, sif, sid, sex, smem, ev;
  logic [31:0] epc;
  logic [5:0] stall;
  logic flush, stall_timeout;
  logic [31:0] new_pc, perf_stall_cyc, perf_flush_cnt;
  int n_chk = 0;
  int n_fail = 0;
  int frem = 0;
  int streak = 0;
  bit mto = 0;
  logic [31:0] mpc = 0;
  int pstall = 0;
  int pflush = 0;
  pipe_ctrl #(.FLUSH_CYCLES(FC), .STALL_LIMIT(LIM), .STALL_CNT_W(3)) dut (
    .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex),
    .stallreq_mem(smem), .excp_valid(ev), .excp_pc(epc), .stall(stall), .flush(flush),
    .new_pc(new_pc), .stall_timeout(stall_timeout), .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic i, input logic d, input logic e,
                      input logic m, input logic x, input logic [31:0] pc);
    int k;
    bit busy, acc, fl;
    logic [5:0] es;
    logic [31:0] ep;
    @(negedge clk);
    rst = r; sif = i; sid = d; sex = e; smem = m; ev = x; epc = pc;
    #1;
    busy = frem > 0;
    acc = !r && !busy && x;
    fl = !r && (busy || acc);
    k = m ? 5 : e ? 4 : d ? 3 : i ? 2 : 0;
    es = (r || fl || k == 0) ? 6'd0 : 6'((1 << k) - 1);
    ep = fl ? (busy ? mpc : pc) : 32'h0;
    check("stall", {26'h0, stall}, {26'h0, es});
    check("flush", {31'h0, flush}, {31'h0, fl});
    check("new_pc", new_pc, ep);
    check("timeout", {31'h0, stall_timeout}, {31'h0, !r && mto});
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall", perf_stall_cyc, pstall);
    check("perf_flush", perf_flush_cnt, pflush);
`else
    check("perf_stall", perf_stall_cyc, 32'h0);
    check("perf_flush", perf_flush_cnt, 32'h0);
`endif
    @(posedge clk);
    if (r) begin
      frem = 0; streak = 0; mto = 0; pstall = 0; pflush = 0;
    end else begin
      if (acc) begin
        frem = FC - 1;
        mpc = pc;
      end else if (busy) frem--;
      streak = es != 0 ? (streak < LIM ? streak + 1 : LIM) : 0;
      if (streak == LIM) mto = 1;
      pstall += int'(es != 0);
      pflush += int'(acc);
    end
  endtask
  initial begin
    step(1, 1, 1, 1, 1, 1, 32'hdead_beef);
    step(1, 1, 1, 1, 1, 1, 32'hdead_beef);
    step(0, 1, 1, 0, 0, 0, 32'h0);
    step(0, 1, 1, 0, 1, 0, 32'h0);
    step(0, 0, 0, 1, 0, 1, 32'h180);
    step(0, 0, 0, 1, 0, 1, 32'h200);
    step(0, 0, 0, 1, 0, 0, 32'h0);
    step(0, 0, 0, 1, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0);
    repeat (4) step(0, 0, 0, 0, 1, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    check("timeout_hold", {31'h0, stall_timeout}, 32'h1);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h300);
    step(1, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0);
    repeat (5) step(0, 1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h400);
    repeat (2) step(0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h500);
    repeat (3) step(0, 0, 0, 0, 0, 0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_5", perf_stall_cyc, 32'd5);
    check("perf_flush_2", perf_flush_cnt, 32'd2);
`else
    check("perf_stall_off", perf_stall_cyc, 32'd0);
    check("perf_flush_off", perf_flush_cnt, 32'd0);
`endif
    for (int n = 0; n < 2000; n++)
      step($urandom_range(49) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
           $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0, $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
